fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and drives the word address into the combinational instruction memory. It registers the returned instruction, its PC and PC+4 into the IF/ID pipeline register. It handles stall and branch-flush requests from hazard/EX logic and stops fetching after an ecall.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: data width, fixed instruction encodings,
// fetch-state encoding and the IF/ID payload used by fetch and decode.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [XLEN-1:0] ECALL_INST = 32'h0000_0073;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// A bubble request wins over load so any redirect can squash the slot.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INST = rv32_pkg::NOP_INST
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bubble_val;

    always_comb begin
        bubble_val       = '0;
        bubble_val.inst  = BUBBLE_INST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= bubble_val;
        end else if (bubble) begin
            q <= bubble_val;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills
// IF/ID. Redirects (flush) beat stalls; an ecall freezes fetch until redirected.
//   state      | meaning
//   FS_RUN     | fetching sequentially, pc advances by 4 each unstalled edge
//   FS_HALTED  | ecall issued once, pc frozen, IF/ID fed bubbles
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int              IMEM_AW    = 6,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST   = rv32_pkg::NOP_INST,
    parameter logic [XLEN-1:0] ECALL_INST = rv32_pkg::ECALL_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [XLEN-1:0]    branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_data,
    output logic [XLEN-1:0]    if_id_inst,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc4,
    output logic               if_id_valid,
    output logic               halted,
    output logic               misalign
);

    fetch_state_e    state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, pc_plus4;
    logic            misalign_nx;
    logic            ifid_load, ifid_bubble;
    if_id_t          ifid_d, ifid_q;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        misalign_nx = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (flush) begin
            // Word-align the target; low bits only raise the misalign pulse.
            pc_nx       = {branch_target[XLEN-1:2], 2'b00};
            misalign_nx = |branch_target[1:0];
            ifid_bubble = 1'b1;
            state_nx    = FS_RUN;
        end else if (!stall) begin
            case (state)
                FS_RUN: begin
                    ifid_load = 1'b1;
                    if (imem_data == ECALL_INST) begin
                        state_nx = FS_HALTED;
                    end else begin
                        pc_nx = pc_plus4;
                    end
                end
                FS_HALTED: begin
                    ifid_bubble = 1'b1;
                end
                default: begin
                    state_nx = FS_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_RUN;
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            misalign <= misalign_nx;
        end
    end

    assign halted = (state == FS_HALTED);

    always_comb begin
        ifid_d       = '0;
        ifid_d.inst  = imem_data;
        ifid_d.pc    = pc;
        ifid_d.pc4   = pc_plus4;
        ifid_d.valid = 1'b1;
    end

    if_id_reg #(
        .BUBBLE_INST (NOP_INST)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_inst  = ifid_q.inst;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, flush, ecall halt,
// misaligned redirect, PC wrap and asynchronous reset while halted.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] I0    = 32'h0050_0093;
    localparam logic [31:0] I1    = 32'h0050_0113;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign;

    logic [31:0] mem [64];
    int n_vec;
    int n_miss;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .misalign      (misalign)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic valid);
        chk({tag, ".inst"},  if_id_inst, inst);
        chk({tag, ".pc"},    if_id_pc, pc);
        chk({tag, ".pc4"},   if_id_pc4, pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic chk_flags(input string tag, input logic [5:0] addr, input logic h, input logic m);
        chk({tag, ".addr"},     {26'd0, imem_addr}, {26'd0, addr});
        chk({tag, ".halted"},   {31'd0, halted}, {31'd0, h});
        chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m});
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0]  = I0;
        mem[1]  = I1;
        mem[8]  = ECALL;
        mem[16] = ECALL;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
        #12;
        chk_ifid("reset", NOP, 32'h0, 32'h0, 1'b0);
        chk_flags("reset", 6'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Sequential fetch
        tick();
        chk_ifid("seq0", I0, 32'h0, 32'h4, 1'b1);
        chk_flags("seq0", 6'd1, 1'b0, 1'b0);
        tick();
        chk_ifid("seq1", I1, 32'h4, 32'h8, 1'b1);
        chk_flags("seq1", 6'd2, 1'b0, 1'b0);

        // Stall three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall", I1, 32'h4, 32'h8, 1'b1);
            chk_flags("stall", 6'd2, 1'b0, 1'b0);
        end
        stall = 1'b0;
        tick();
        chk_ifid("resume", NOP, 32'h8, 32'hC, 1'b1);
        chk_flags("resume", 6'd3, 1'b0, 1'b0);

        // Flush and stall together: flush wins
        stall = 1'b1; flush = 1'b1; branch_target = 32'h20;
        tick();
        chk_ifid("flush_stall", NOP, 32'h0, 32'h0, 1'b0);
        chk_flags("flush_stall", 6'd8, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;

        // Ecall at word 8: issued once, then bubbles
        tick();
        chk_ifid("ecall", ECALL, 32'h20, 32'h24, 1'b1);
        chk_flags("ecall", 6'd8, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_ifid("halt_bub", NOP, 32'h0, 32'h0, 1'b0);
            chk_flags("halt_bub", 6'd8, 1'b1, 1'b0);
        end
        // Stall while halted keeps the bubble
        stall = 1'b1;
        tick();
        chk_ifid("halt_stall", NOP, 32'h0, 32'h0, 1'b0);
        chk_flags("halt_stall", 6'd8, 1'b1, 1'b0);
        stall = 1'b0;

        // Redirect out of halt
        flush = 1'b1; branch_target = 32'h04;
        tick();
        chk_ifid("unhalt", NOP, 32'h0, 32'h0, 1'b0);
        chk_flags("unhalt", 6'd1, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        chk_ifid("unhalt_fetch", I1, 32'h4, 32'h8, 1'b1);
        chk_flags("unhalt_fetch", 6'd2, 1'b0, 1'b0);

        // Misaligned redirect
        flush = 1'b1; branch_target = 32'h16;
        tick();
        chk_flags("misal", 6'd5, 1'b0, 1'b1);
        flush = 1'b0;
        tick();
        chk_ifid("misal_fetch", NOP, 32'h14, 32'h18, 1'b1);
        chk_flags("misal_fetch", 6'd6, 1'b0, 1'b0);

        // PC wraps at the top of the address space
        flush = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        chk_flags("wrap_flush", 6'd63, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        chk_ifid("wrap", NOP, 32'hFFFF_FFFC, 32'h0, 1'b1);
        chk_flags("wrap", 6'd0, 1'b0, 1'b0);

        // Flush coincident with an ecall on imem_data: no halt
        flush = 1'b1; branch_target = 32'h20;
        tick();
        chk("ecall_on_bus", imem_data, ECALL);
        branch_target = 32'h40;
        tick();
        chk_flags("flush_ecall", 6'd16, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        chk_ifid("halt40", ECALL, 32'h40, 32'h44, 1'b1);
        chk_flags("halt40", 6'd16, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while halted
        #1;
        rst = 1'b1;
        #1;
        chk_ifid("async_rst", NOP, 32'h0, 32'h0, 1'b0);
        chk_flags("async_rst", 6'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_ifid("post_rst", I0, 32'h0, 32'h4, 1'b1);
        chk_flags("post_rst", 6'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
